// File: rtl/waiter_scheduler.sv
// Round-robin arbiter that time-shares one Waiter delay timer among NUM_REQ requesters.
// Optional watchdog on the WAIT state is enabled by defining WAITER_SCHED_WATCHDOG_EN.
module waiter_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int COUNTER_SIZE = 8,
    parameter int WD_MARGIN    = 4
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*COUNTER_SIZE-1:0] req_count_i,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic [NUM_REQ-1:0]              done_o,
    output logic                            busy_o,
    output logic                            timeout_o,
    output logic                            timer_start_o,
    output logic [COUNTER_SIZE-1:0]         timer_count_to_o,
    input  logic                            timer_busy_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q, rr_q;
    logic [COUNTER_SIZE-1:0]   cnt_q;
    logic [NUM_REQ-1:0]        grant_q, done_q;
    logic                      start_q, busy_q;

    logic [COUNTER_SIZE-1:0]   cnt_arr [NUM_REQ];
    logic [IDX_W-1:0]          pick_idx_d;
    logic [COUNTER_SIZE-1:0]   pick_cnt_d;
    logic                      pick_vld_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign cnt_arr[g] = req_count_i[g*COUNTER_SIZE +: COUNTER_SIZE];
    end

    // First pending requester at or after the rr pointer, wrapping around.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        j          = 0;
        jj         = '0;
        pick_idx_d = rr_q;
        pick_cnt_d = '0;
        pick_vld_d = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = IDX_W'(j);
            if (!pick_vld_d && req_i[jj]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = jj;
                pick_cnt_d = cnt_arr[jj];
            end
        end
    end

`ifdef WAITER_SCHED_WATCHDOG_EN
    logic [COUNTER_SIZE:0] wd_q;
    logic                  timeout_q;
    logic [COUNTER_SIZE:0] wd_d, wd_lim;
    assign wd_d      = wd_q + (COUNTER_SIZE+1)'(1);
    assign wd_lim    = {1'b0, cnt_q} + (COUNTER_SIZE+1)'(WD_MARGIN);
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef WAITER_SCHED_WATCHDOG_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        idx_q   <= pick_idx_d;
                        cnt_q   <= pick_cnt_d;
                        grant_q <= NUM_REQ'(1) << pick_idx_d;
                        busy_q  <= 1'b1;
                        // A zero delay never touches the timer.
                        if (pick_cnt_d == '0) begin
                            state_q <= DONE;
                            done_q  <= NUM_REQ'(1) << pick_idx_d;
                        end else begin
                            state_q <= START;
                            start_q <= 1'b1;
                        end
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
`ifdef WAITER_SCHED_WATCHDOG_EN
                    wd_q    <= '0;
`endif
                end
                WAIT: begin
`ifdef WAITER_SCHED_WATCHDOG_EN
                    wd_q <= wd_d;
                    if (!timer_busy_i) begin
                        state_q <= DONE;
                        done_q  <= NUM_REQ'(1) << idx_q;
                    end else if (wd_d >= wd_lim) begin
                        state_q   <= DONE;
                        done_q    <= NUM_REQ'(1) << idx_q;
                        timeout_q <= 1'b1;
                    end
`else
                    if (!timer_busy_i) begin
                        state_q <= DONE;
                        done_q  <= NUM_REQ'(1) << idx_q;
                    end
`endif
                end
                DONE: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    rr_q    <= (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + IDX_W'(1);
                    state_q <= IDLE;
`ifdef WAITER_SCHED_WATCHDOG_EN
                    timeout_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o          = grant_q;
    assign done_o           = done_q;
    assign busy_o           = busy_q;
    assign timer_start_o    = start_q;
    assign timer_count_to_o = cnt_q;

endmodule

// File: tb/tb_waiter_scheduler.sv
// Bench for waiter_scheduler with a behavioural Waiter on the timer ports and a
// scoreboard of expected (requester, cycle) done events.
module tb_waiter_scheduler;
    localparam int NR = 4;
    localparam int CS = 8;
    localparam int WM = 4;

    typedef struct { int idx; int cyc; } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*CS-1:0]  req_count = '0;
    logic [NR-1:0]     grant, done;
    logic              busy, timeout, timer_start, timer_busy;
    logic [CS-1:0]     timer_count_to;

    logic              w_busy_q;
    logic [CS-1:0]     w_cnt_q;
    logic              force_busy = 1'b0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Waiter: busy for count_to cycles starting the cycle after start.
    always @(posedge clock) begin
        if (reset) begin
            w_busy_q <= 1'b0;
            w_cnt_q  <= '0;
        end else if (timer_start) begin
            w_cnt_q  <= timer_count_to;
            w_busy_q <= (timer_count_to != '0);
        end else if (w_busy_q) begin
            w_cnt_q <= w_cnt_q - 1'b1;
            if (w_cnt_q == 8'd1) w_busy_q <= 1'b0;
        end
    end
    assign timer_busy = force_busy | w_busy_q;

    waiter_scheduler #(.NUM_REQ(NR), .COUNTER_SIZE(CS), .WD_MARGIN(WM)) dut (
        .clock_i(clock), .reset_i(reset), .req_i(req), .req_count_i(req_count),
        .grant_o(grant), .done_o(done), .busy_o(busy), .timeout_o(timeout),
        .timer_start_o(timer_start), .timer_count_to_o(timer_count_to),
        .timer_busy_i(timer_busy));

    task automatic test_reset();
        reset = 1'b1; req = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if ({grant, done, busy, timeout, timer_start, timer_count_to} !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d grant=%b done=%b busy=%b to=%b start=%b cnt=%0d expected all 0",
                         cyc, grant, done, busy, timeout, timer_start, timer_count_to);
            end
        end
    endtask

    task automatic test_single();
        int c0, s;
        exp_t e;
        @(negedge clock);
        req_count[0 +: CS] = 8'd3; req = 4'b0001;
        c0 = cyc; s = c0 + 1;
        sb.push_back('{0, c0 + 6});
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (cyc >= s && cyc <= s + 5) begin
                checks++;
                if (timer_count_to !== 8'd3) begin
                    errors++;
                    $display("FAIL single_count_to cyc=%0d got %0d expected 3", cyc, timer_count_to);
                end
            end
            if (cyc == s + 6) begin
                checks++;
                if (timer_count_to !== 8'd0) begin
                    errors++;
                    $display("FAIL single_count_idle got %0d expected 0", timer_count_to);
                end
            end
            checks++;
            if (timer_start !== (cyc == s)) begin
                errors++;
                $display("FAIL single_start cyc=%0d got %b expected %b", cyc, timer_start, (cyc == s));
            end
            if (done !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL single_unexpected_done cyc=%0d done=%b", cyc, done);
                end else begin
                    e = sb.pop_front();
                    if (done !== 4'(1 << e.idx) || cyc != e.cyc || timeout !== 1'b0) begin
                        errors++;
                        $display("FAIL single_done got done=%b cyc=%0d to=%b expected done=%b cyc=%0d to=0",
                                 done, cyc, timeout, 4'(1 << e.idx), e.cyc);
                    end
                end
                req = '0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_missing_done got %0d pending expected 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_round_robin();
        int c0, n;
        exp_t e;
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        for (int i = 0; i < NR; i++) req_count[i*CS +: CS] = 8'd2;
        req = 4'b1111;
        c0 = cyc;
        for (int k = 0; k < 5; k++) sb.push_back('{k % NR, c0 + 5 + 6*k});
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clock); n++;
            checks++;
            if ($countones(grant) > 1 || $countones(done) > 1) begin
                errors++;
                $display("FAIL rr_onehot cyc=%0d grant=%b done=%b expected at most one bit", cyc, grant, done);
            end
            if (done !== '0) begin
                checks++;
                e = sb.pop_front();
                if (done !== 4'(1 << e.idx) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rr_order got done=%b cyc=%0d expected done=%b cyc=%0d",
                             done, cyc, 4'(1 << e.idx), e.cyc);
                end
                if (sb.size() == 0) req = '0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rr_timeout got %0d pending expected 0", sb.size());
        end
        sb.delete();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (done !== '0) begin
                errors++;
                $display("FAIL rr_extra_done got %b expected 0", done);
            end
        end
    endtask

    task automatic test_zero_count();
        int c0;
        exp_t e;
        @(negedge clock);
        req_count[2*CS +: CS] = 8'd0; req = 4'b0100;
        c0 = cyc;
        sb.push_back('{2, c0 + 1});
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++;
            if (timer_start !== 1'b0) begin
                errors++;
                $display("FAIL zero_start cyc=%0d got %b expected 0", cyc, timer_start);
            end
            if (done !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL zero_unexpected_done cyc=%0d done=%b", cyc, done);
                end else begin
                    e = sb.pop_front();
                    if (done !== 4'(1 << e.idx) || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL zero_done got done=%b cyc=%0d expected done=%b cyc=%0d",
                                 done, cyc, 4'(1 << e.idx), e.cyc);
                    end
                end
                req = '0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL zero_missing_done got %0d pending expected 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int c0, s, n;
        @(negedge clock);
        req_count[0 +: CS] = 8'd10; req = 4'b0001;
        c0 = cyc; s = c0 + 1;
        n = 0;
        while (cyc < s + 2 && n < 10) begin
            @(negedge clock); n++;
        end
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre grant=%b busy=%b expected 0001 1", grant, busy);
        end
        reset = 1'b1; req = '0;
        @(negedge clock);
        checks++;
        if (grant !== '0 || busy !== 1'b0 || done !== '0) begin
            errors++;
            $display("FAIL mid_reset grant=%b busy=%b done=%b expected 0 0 0", grant, busy, done);
        end
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            checks++;
            if (done !== '0 || timer_start !== 1'b0) begin
                errors++;
                $display("FAIL mid_after cyc=%0d done=%b start=%b expected 0 0", cyc, done, timer_start);
            end
        end
    endtask

`ifdef WAITER_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int c0;
        exp_t e;
        @(negedge clock);
        force_busy = 1'b1;
        req_count[0 +: CS] = 8'd5; req = 4'b0001;
        c0 = cyc;
        sb.push_back('{0, c0 + 2 + 9});
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wd_unexpected_done cyc=%0d done=%b", cyc, done);
                end else begin
                    e = sb.pop_front();
                    if (done !== 4'(1 << e.idx) || cyc != e.cyc || timeout !== 1'b1) begin
                        errors++;
                        $display("FAIL wd_done got done=%b cyc=%0d to=%b expected done=%b cyc=%0d to=1",
                                 done, cyc, timeout, 4'(1 << e.idx), e.cyc);
                    end
                end
                req = '0; force_busy = 1'b0;
            end else begin
                checks++;
                if (timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_stray_timeout cyc=%0d got 1 expected 0", cyc);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wd_missing_done got %0d pending expected 0", sb.size());
        end
        sb.delete();
        force_busy = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_count();
        test_reset_mid();
`ifdef WAITER_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
